// File: rtl/mips_pkg.sv
// Shared fetch-side constants: reset address, NOP, word size and FSM encoding.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES       = 32'd4;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_FULL = 2'b10;
  localparam logic [1:0] ST_DROP = 2'b11;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + WORD_BYTES;
  endfunction

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding a fetched word and its pc while decode stalls.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  logic [31:0] load_data,
  input  logic [31:0] load_pc,
  output logic [31:0] data,
  output logic [31:0] pc,
  output logic        valid
);

  // Flush beats load so a redirect never leaves a stale entry behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= NOP;
      pc    <= 32'h0000_0000;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      pc    <= load_pc;
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single outstanding memory request, skid buffer
// behind the output register, and branch redirect with in-flight drop.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  logic [1:0]  state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] drop_addr_r, drop_addr_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] instr_pc_r, instr_pc_s;
  logic        valid_r, valid_s;
  logic        skid_load_s, skid_unload_s, skid_flush_s;
  logic [31:0] skid_data_s, skid_pc_s;
  logic        skid_valid_s;
  logic        ack_s, consume_s;

  assign imem_req    = (state_r == ST_REQ) || (state_r == ST_DROP);
  // DROP keeps presenting the abandoned address until memory answers it.
  assign imem_addr   = (state_r == ST_DROP) ? drop_addr_r : pc_r;
  assign ack_s       = imem_ack && imem_req;
  assign consume_s   = valid_r && !stall;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = valid_r;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load_s),
    .unload    (skid_unload_s),
    .flush     (skid_flush_s),
    .load_data (imem_rdata),
    .load_pc   (pc_r),
    .data      (skid_data_s),
    .pc        (skid_pc_s),
    .valid     (skid_valid_s)
  );

  // Next-state logic; a redirect overrides ack, stall and consumption.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    drop_addr_s   = drop_addr_r;
    instr_s       = instr_r;
    instr_pc_s    = instr_pc_r;
    valid_s       = valid_r;
    skid_load_s   = 1'b0;
    skid_unload_s = 1'b0;
    skid_flush_s  = 1'b0;
    if (branch_taken) begin
      pc_s         = align_word(branch_target);
      valid_s      = 1'b0;
      skid_flush_s = 1'b1;
      case (state_r)
        ST_REQ: begin
          if (ack_s) begin
            state_s = ST_REQ;
          end else begin
            state_s     = ST_DROP;
            drop_addr_s = pc_r;
          end
        end
        ST_DROP: begin
          if (ack_s) state_s = ST_REQ;
          else       state_s = ST_DROP;
        end
        default: state_s = ST_REQ;
      endcase
    end else begin
      if (consume_s) valid_s = 1'b0;
      else           valid_s = valid_r;
      case (state_r)
        ST_IDLE: state_s = ST_REQ;
        ST_REQ: begin
          if (ack_s) begin
            pc_s = next_pc(pc_r);
            if (!valid_r || consume_s) begin
              instr_s    = imem_rdata;
              instr_pc_s = pc_r;
              valid_s    = 1'b1;
              state_s    = ST_REQ;
            end else begin
              skid_load_s = 1'b1;
              state_s     = ST_FULL;
            end
          end else begin
            state_s = ST_REQ;
          end
        end
        ST_FULL: begin
          if (!skid_valid_s) begin
            state_s = ST_REQ;
          end else if (consume_s) begin
            instr_s       = skid_data_s;
            instr_pc_s    = skid_pc_s;
            valid_s       = 1'b1;
            skid_unload_s = 1'b1;
            state_s       = ST_REQ;
          end else begin
            state_s = ST_FULL;
          end
        end
        ST_DROP: begin
          if (ack_s) state_s = ST_REQ;
          else       state_s = ST_DROP;
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      pc_r        <= RESET_PC;
      drop_addr_r <= RESET_PC;
      instr_r     <= NOP;
      instr_pc_r  <= RESET_PC;
      valid_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      drop_addr_r <= drop_addr_s;
      instr_r     <= instr_s;
      instr_pc_r  <= instr_pc_s;
      valid_r     <= valid_s;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: latency-programmable memory model plus
// an in-order scoreboard of fetched words checked at every consumption.
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, stall, branch_taken, instr_valid;
  logic [31:0] imem_addr, imem_rdata, branch_target, instr, instr_pc;
  logic        w_req, w_ack, w_valid;
  logic        w_stall = 1'b0;
  logic        w_branch = 1'b0;
  logic [31:0] w_target = 32'h0;
  logic [31:0] w_addr, w_rdata, w_instr, w_instr_pc;

  int  lat;
  int  wait_cnt;
  int  total = 0;
  int  bad = 0;
  int  pops = 0;
  bit  dropping = 1'b0;
  sb_t sb_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0004) return 32'h8C00_0000;
    else                    return a ^ 32'hA5A5_5A5A;
  endfunction

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .stall(w_stall),
    .branch_taken(w_branch), .branch_target(w_target),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_valid)
  );

  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = mem_word(imem_addr);
  assign w_ack      = w_req;
  assign w_rdata    = mem_word(w_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       wait_cnt <= 0;
    else if (imem_req && !imem_ack)   wait_cnt <= wait_cnt + 1;
    else                              wait_cnt <= 0;
  end

  // Values at a falling edge are exactly those the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      dropping = 1'b0;
    end else begin
      if (instr_valid && !stall) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_empty: consumed pc=%h instr=%h, required no live instr", instr_pc, instr);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          pops++;
          if (instr_pc !== e.pc || instr !== e.data) begin
            bad++;
            $display("FAIL sb_order: got pc=%h instr=%h, exp pc=%h instr=%h", instr_pc, instr, e.pc, e.data);
          end
        end
      end
      if (branch_taken) begin
        sb_q.delete();
        dropping = imem_req && !imem_ack;
      end else if (imem_req && imem_ack) begin
        if (dropping) dropping = 1'b0;
        else          sb_q.push_back({imem_addr, mem_word(imem_addr)});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset(input int l, input logic s);
    step();
    rst_n = 1'b0; lat = l; stall = s;
    branch_taken = 1'b0; branch_target = 32'h0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got=%b exp=0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got=%h exp=0", imem_addr); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got=%h exp=0", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc: got=%h exp=0", instr_pc); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got=%b exp=0", instr_valid); end
    total++; if (w_addr !== 32'hFFFF_FFFC || w_instr_pc !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL rst_w_pc: got addr=%h instr_pc=%h exp fffffffc", w_addr, w_instr_pc);
    end
  endtask

  task automatic test_stream();
    int vcnt = 0;
    do_reset(0, 1'b0);
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) sample();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL stream_first: got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
    end
    sample();
    total++; if (imem_addr !== 32'h4 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      bad++; $display("FAIL stream_second: got addr=%h valid=%b pc=%h exp 4/1/0", imem_addr, instr_valid, instr_pc);
    end
    sample();
    total++; if (imem_addr !== 32'h8 || instr !== 32'h8C00_0000 || instr_pc !== 32'h4) begin
      bad++; $display("FAIL stream_third: got addr=%h instr=%h pc=%h exp 8/8c000000/4", imem_addr, instr, instr_pc);
    end
    for (int i = 0; i < 6; i++) begin
      sample();
      if (instr_valid === 1'b1) vcnt++;
    end
    total++; if (vcnt != 6) begin bad++; $display("FAIL stream_rate: got=%0d valid cycles exp=6", vcnt); end
  endtask

  task automatic test_stall_skid();
    do_reset(0, 1'b1);
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) sample();
    sample();
    sample();
    total++; if (imem_req !== 1'b0 || instr_pc !== 32'h0 || instr_valid !== 1'b1) begin
      bad++; $display("FAIL skid_full: got req=%b pc=%h valid=%b exp 0/0/1", imem_req, instr_pc, instr_valid);
    end
    step();
    stall = 1'b0;
    sample();
    sample();
    total++; if (instr_pc !== 32'h4 || instr !== 32'h8C00_0000) begin
      bad++; $display("FAIL skid_unload: got pc=%h instr=%h exp 4/8c000000", instr_pc, instr);
    end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      bad++; $display("FAIL skid_resume: got req=%b addr=%h exp 1/8", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_drop();
    do_reset(3, 1'b0);
    for (int i = 0; i < 60 && !(imem_req === 1'b1 && imem_addr === 32'h8); i++) sample();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      bad++; $display("FAIL br_req8: got req=%b addr=%h exp 1/8", imem_req, imem_addr);
    end
    step();
    branch_taken = 1'b1; branch_target = 32'h40;
    sample();
    step();
    branch_taken = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
        bad++; $display("FAIL br_hold: got req=%b addr=%h exp 1/8", imem_req, imem_addr);
      end
      total++; if (instr_valid !== 1'b0 || instr !== 32'h8C00_0000) begin
        bad++; $display("FAIL br_flushed: got valid=%b instr=%h exp 0/8c000000", instr_valid, instr);
      end
      if (imem_ack === 1'b1) break;
    end
    total++; if (imem_ack !== 1'b1) begin bad++; $display("FAIL br_ack_timeout: got ack=%b exp 1", imem_ack); end
    sample();
    total++; if (imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL br_new_req: got addr=%h valid=%b exp 40/0", imem_addr, instr_valid);
    end
    for (int i = 0; i < 10 && instr_valid !== 1'b1; i++) sample();
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin
      bad++; $display("FAIL br_target_data: got valid=%b pc=%h exp 1/40", instr_valid, instr_pc);
    end
  endtask

  task automatic test_align();
    do_reset(0, 1'b0);
    for (int i = 0; i < 5; i++) sample();
    step();
    branch_taken = 1'b1; branch_target = 32'h43;
    sample();
    step();
    branch_taken = 1'b0;
    sample();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL align: got req=%b addr=%h valid=%b exp 1/40/0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset(0, 1'b0);
    for (int i = 0; i < 10 && w_req !== 1'b1; i++) sample();
    total++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_first: got req=%b addr=%h exp 1/fffffffc", w_req, w_addr);
    end
    sample();
    total++; if (w_addr !== 32'h0) begin bad++; $display("FAIL wrap_second: got addr=%h exp 0", w_addr); end
    total++; if (w_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFFC || w_instr !== 32'h5A5A_A5A6) begin
      bad++; $display("FAIL wrap_instr: got valid=%b pc=%h instr=%h exp 1/fffffffc/5a5aa5a6", w_valid, w_instr_pc, w_instr);
    end
  endtask

  task automatic test_async_reset();
    do_reset(3, 1'b1);
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) sample();
    total++; if (instr_valid !== 1'b1 || imem_req !== 1'b1) begin
      bad++; $display("FAIL arst_setup: got valid=%b req=%b exp 1/1", instr_valid, imem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL arst_immediate: got req=%b valid=%b exp 0/0", imem_req, instr_valid);
    end
    total++; if (imem_addr !== 32'h0 || instr !== 32'h0) begin
      bad++; $display("FAIL arst_values: got addr=%h instr=%h exp 0/0", imem_addr, instr);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) sample();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL arst_restart: got req=%b addr=%h exp 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    int pops_start;
    do_reset(1, 1'b0);
    pops_start = pops;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 150) lat = 0;
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 15) == 0);
      branch_target = $urandom & 32'h0000_0FFF;
    end
    step();
    branch_taken = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 5; i++) sample();
    total++; if (pops - pops_start < 50) begin
      bad++; $display("FAIL b2b_throughput: got=%0d consumed exp>=50", pops - pops_start);
    end
  endtask

  initial begin
    rst_n = 1'b0; lat = 0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    test_reset();
    test_stream();
    test_stall_skid();
    test_branch_drop();
    test_align();
    test_wrap();
    test_async_reset();
    test_back_to_back();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
